// File: rtl/plot_pkg.sv
// plot_pkg: shared FSM state type, default port widths and framebuffer addressing.
package plot_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, SCAN} state_e;
    localparam int X_BITS_DEF = 8;
    localparam int Y_BITS_DEF = 7;
    localparam int C_BITS_DEF = 3;
    function automatic int fb_addr(input int x, input int y, input int w);
        return y * w + x;
    endfunction
endpackage

// File: rtl/fb_ram_1w1r.sv
// fb_ram_1w1r: simple dual-port framebuffer store, synchronous read with read enable, no reset.
module fb_ram_1w1r #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 3,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/plot_framebuffer_sink.sv
// plot_framebuffer_sink: captures plotted pixels into a framebuffer, clears it, and replays it as a raster stream.
// Define PIXEL_COUNT_EN to enable the saturating accepted-write counter on pix_count_o.
module plot_framebuffer_sink
    import plot_pkg::*;
#(
    parameter int FB_W   = 16,
    parameter int FB_H   = 16,
    parameter int X_BITS = X_BITS_DEF,
    parameter int Y_BITS = Y_BITS_DEF,
    parameter int C_BITS = C_BITS_DEF
) (
    input  logic              clock_i,
    input  logic              resetn_i,
    input  logic              plot_i,
    input  logic [X_BITS-1:0] x_i,
    input  logic [Y_BITS-1:0] y_i,
    input  logic [C_BITS-1:0] colour_i,
    output logic              plot_ready_o,
    input  logic              clear_req_i,
    input  logic [C_BITS-1:0] bg_colour_i,
    input  logic              scan_start_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [X_BITS-1:0] out_x_o,
    output logic [Y_BITS-1:0] out_y_o,
    output logic [C_BITS-1:0] out_colour_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              clip_err_o,
    output logic [15:0]       pix_count_o
);
    localparam int N  = FB_W * FB_H;
    localparam int AW = $clog2(N);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] N_C    = CW'(N);
    localparam logic [AW-1:0] LAST_A = AW'(N - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     s1_addr_q, out_addr_q, waddr;
    logic              s1_v_q, ov_q, clip_q;
    logic [C_BITS-1:0] bg_q, out_colour_q, rdata, wdata;
    logic              clear_go, scan_go, advance, re, in_range, plot_we, we;

    assign clear_go     = state_q == IDLE && clear_req_i;
    assign scan_go      = state_q == IDLE && scan_start_i && !clear_req_i;
    // Two-stage pipeline (RAM read register, output register) stalls as a unit.
    assign advance      = !ov_q || out_ready_i;
    assign re           = advance && (scan_go || (state_q == SCAN && cnt_q < N_C));
    assign in_range     = int'(x_i) < FB_W && int'(y_i) < FB_H;
    assign plot_ready_o = state_q != CLEAR;
    assign plot_we      = plot_i && plot_ready_o && in_range;
    assign we           = state_q == CLEAR || plot_we;
    assign waddr        = state_q == CLEAR ? cnt_q[AW-1:0] : AW'(fb_addr(int'(x_i), int'(y_i), FB_W));
    assign wdata        = state_q == CLEAR ? bg_q : colour_i;

    assign out_valid_o  = ov_q;
    assign out_last_o   = ov_q && out_addr_q == LAST_A;
    assign out_x_o      = X_BITS'(int'(out_addr_q) % FB_W);
    assign out_y_o      = Y_BITS'(int'(out_addr_q) / FB_W);
    assign out_colour_o = out_colour_q;
    assign busy_o       = state_q != IDLE;
    assign clip_err_o   = clip_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = clear_req_i ? CLEAR : scan_start_i ? SCAN : IDLE;
            CLEAR:   state_d = cnt_q == CW'(N - 1) ? IDLE : CLEAR;
            SCAN:    state_d = out_last_o && out_ready_i ? IDLE : SCAN;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d == IDLE || (state_q == IDLE && state_d == CLEAR)) ? '0
              : cnt_q + CW'(state_q == CLEAR || re);
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bg_q         <= '0;
            s1_v_q       <= 1'b0;
            s1_addr_q    <= '0;
            ov_q         <= 1'b0;
            out_addr_q   <= '0;
            out_colour_q <= '0;
            clip_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (clear_go) bg_q <= bg_colour_i;
            if (advance) begin
                s1_v_q       <= re;
                s1_addr_q    <= cnt_q[AW-1:0];
                ov_q         <= s1_v_q;
                out_addr_q   <= s1_addr_q;
                out_colour_q <= rdata;
            end
            if (clear_go) clip_q <= 1'b0;
            else if (plot_i && plot_ready_o && !in_range) clip_q <= 1'b1;
        end
    end

`ifdef PIXEL_COUNT_EN
    logic [15:0] pix_q;
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) pix_q <= '0;
        else if (clear_go) pix_q <= '0;
        else if (plot_we && pix_q != 16'hFFFF) pix_q <= pix_q + 16'd1;
    end
    assign pix_count_o = pix_q;
`else
    assign pix_count_o = '0;
`endif

    fb_ram_1w1r #(.DEPTH(N), .WIDTH(C_BITS)) u_ram (
        .clk_i   (clock_i),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .re_i    (re),
        .raddr_i (cnt_q[AW-1:0]),
        .rdata_o (rdata)
    );
endmodule

// File: tb/tb_plot_framebuffer_sink.sv
// tb_plot_framebuffer_sink: directed scenario tests against a bench-side framebuffer model.
module tb_plot_framebuffer_sink;
    logic        clk = 1'b0, resetn = 1'b1, plot = 1'b0;
    logic [7:0]  x = '0;
    logic [6:0]  y = '0;
    logic [2:0]  colour = '0, bg = '0;
    logic        clear_req = 1'b0, scan_start = 1'b0, out_ready = 1'b0;
    logic        plot_ready, out_valid, out_last, busy, clip_err;
    logic [7:0]  out_x;
    logic [6:0]  out_y;
    logic [2:0]  out_colour;
    logic [15:0] pix_count;
    logic [2:0]  mem_m [256];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    plot_framebuffer_sink dut (
        .clock_i      (clk),
        .resetn_i     (resetn),
        .plot_i       (plot),
        .x_i          (x),
        .y_i          (y),
        .colour_i     (colour),
        .plot_ready_o (plot_ready),
        .clear_req_i  (clear_req),
        .bg_colour_i  (bg),
        .scan_start_i (scan_start),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_x_o      (out_x),
        .out_y_o      (out_y),
        .out_colour_o (out_colour),
        .out_last_o   (out_last),
        .busy_o       (busy),
        .clip_err_o   (clip_err),
        .pix_count_o  (pix_count)
    );

    task automatic plot_px(input int px, input int py, input logic [2:0] c);
        plot = 1'b1; x = 8'(px); y = 7'(py); colour = c;
        @(posedge clk); #1;
        plot = 1'b0;
        if (px < 16 && py < 16) mem_m[py * 16 + px] = c;
    endtask

    task automatic do_clear(input logic [2:0] c);
        int n;
        n = 0;
        clear_req = 1'b1; bg = c;
        @(posedge clk); #1;
        clear_req = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        checks++;
        if (n !== 256) begin
            errors++; $display("FAIL clear_busy_cycles got %0d want 256", n);
        end
        for (int i = 0; i < 256; i++) mem_m[i] = c;
    endtask

    task automatic run_scan(input bit rnd, input string tag);
        int beat, cyc, first;
        bit held;
        logic [7:0] hx;
        logic [6:0] hy;
        logic [2:0] hc;
        beat = 0; cyc = 0; first = -1; held = 0; hx = '0; hy = '0; hc = '0;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0; cyc = 1;
        while (beat < 256 && cyc < 3000) begin
            @(negedge clk);
            if (out_valid && first < 0) first = cyc;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_x !== hx || out_y !== hy || out_colour !== hc) begin
                    errors++;
                    $display("FAIL %s stall_hold beat %0d got v=%b x=%0d y=%0d c=%0d want v=1 x=%0d y=%0d c=%0d",
                             tag, beat, out_valid, out_x, out_y, out_colour, hx, hy, hc);
                end
            end
            held = out_valid && !out_ready;
            hx = out_x; hy = out_y; hc = out_colour;
            if (out_valid && out_ready) begin
                checks++;
                if (out_x !== 8'(beat % 16) || out_y !== 7'(beat / 16) || out_colour !== mem_m[beat]
                    || out_last !== (beat == 255)) begin
                    errors++;
                    $display("FAIL %s beat %0d got x=%0d y=%0d c=%0d last=%b want x=%0d y=%0d c=%0d last=%b",
                             tag, beat, out_x, out_y, out_colour, out_last, beat % 16, beat / 16, mem_m[beat], beat == 255);
                end
                beat++;
            end
            @(posedge clk); #1;
            cyc++;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        checks++;
        if (first !== 2) begin
            errors++; $display("FAIL %s first_valid_latency got %0d want 2", tag, first);
        end
        checks++;
        if (beat !== 256) begin
            errors++; $display("FAIL %s beat_total got %0d want 256", tag, beat);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s scan_end got valid=%b busy=%b want 0 0", tag, out_valid, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1 resetn = 1'b0;
        #2;
        checks++;
        if ({plot_ready, busy, out_valid, out_last, clip_err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b want 10000", {plot_ready, busy, out_valid, out_last, clip_err});
        end
        checks++;
        if (out_x !== 8'd0 || out_y !== 7'd0 || out_colour !== 3'd0 || pix_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_values got x=%0d y=%0d c=%0d pix=%0d want 0 0 0 0", out_x, out_y, out_colour, pix_count);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_clear_scan;
        do_clear(3'b001);
        run_scan(1'b0, "clear_scan");
    endtask

    task automatic test_square;
        for (int yy = 3; yy < 7; yy++)
            for (int xx = 2; xx < 6; xx++) plot_px(xx, yy, 3'b100);
        @(negedge clk);
        checks++;
`ifdef PIXEL_COUNT_EN
        if (pix_count !== 16'd16) begin
            errors++; $display("FAIL square_pix_count got %0d want 16", pix_count);
        end
`else
        if (pix_count !== 16'd0) begin
            errors++; $display("FAIL square_pix_count got %0d want 0", pix_count);
        end
`endif
        run_scan(1'b0, "square");
    endtask

    task automatic test_clip;
        plot_px(16, 0, 3'b010);
        @(negedge clk);
        checks++;
        if (clip_err !== 1'b1) begin
            errors++; $display("FAIL clip_set got %b want 1", clip_err);
        end
        run_scan(1'b0, "clip_nowrite");
        checks++;
        if (clip_err !== 1'b1) begin
            errors++; $display("FAIL clip_sticky got %b want 1", clip_err);
        end
        do_clear(3'b010);
        checks++;
        if (clip_err !== 1'b0) begin
            errors++; $display("FAIL clip_cleared got %b want 0", clip_err);
        end
    endtask

    task automatic test_stall;
        plot_px(0, 0, 3'b111);
        plot_px(7, 8, 3'b011);
        plot_px(15, 15, 3'b110);
        run_scan(1'b1, "stall");
    endtask

    task automatic test_clear_wins;
        int n;
        bit saw_valid;
        saw_valid = 0;
        clear_req = 1'b1; scan_start = 1'b1; bg = 3'b101;
        @(posedge clk); #1;
        clear_req = 1'b0; scan_start = 1'b0;
        plot = 1'b1; x = 8'd5; y = 7'd5; colour = 3'b111;
        @(negedge clk);
        checks++;
        if (plot_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL clear_plot_ready got ready=%b busy=%b want 0 1", plot_ready, busy);
        end
        @(posedge clk); #1;
        x = 8'd20;
        @(posedge clk); #1;
        plot = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
            n++;
        end
        for (int i = 0; i < 256; i++) mem_m[i] = 3'b101;
        checks++;
        if (busy !== 1'b0 || saw_valid) begin
            errors++; $display("FAIL clear_wins got busy=%b valid_seen=%b want 0 0", busy, saw_valid);
        end
        checks++;
        if (clip_err !== 1'b0) begin
            errors++; $display("FAIL clear_clip got %b want 0", clip_err);
        end
        run_scan(1'b0, "clear_wins");
    endtask

    task automatic test_reset_mid_scan;
        int beat;
        beat = 0;
        out_ready = 1'b1;
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (beat == 100) break;
                beat++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (beat !== 100 || out_valid !== 1'b1 || out_x !== 8'd4 || out_y !== 7'd6 || out_colour !== mem_m[100]) begin
            errors++;
            $display("FAIL mid_scan_pixel got beat=%0d v=%b x=%0d y=%0d c=%0d want 100 1 4 6 %0d",
                     beat, out_valid, out_x, out_y, out_colour, mem_m[100]);
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || pix_count !== 16'd0) begin
            errors++; $display("FAIL async_reset got valid=%b busy=%b pix=%0d want 0 0 0", out_valid, busy, pix_count);
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) plot_px(i % 16, 10 + i / 16, 3'b110);
        @(negedge clk);
        checks++;
`ifdef PIXEL_COUNT_EN
        if (pix_count !== 16'd20) begin
            errors++; $display("FAIL pix_count_20 got %0d want 20", pix_count);
        end
`else
        if (pix_count !== 16'd0) begin
            errors++; $display("FAIL pix_count_20 got %0d want 0", pix_count);
        end
`endif
        run_scan(1'b0, "after_reset");
    endtask

    initial begin
        test_reset;
        test_clear_scan;
        test_square;
        test_clip;
        test_stall;
        test_clear_wins;
        test_reset_mid_scan;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
